// File: rtl/mips_pkg.sv
// Shared MIPS core constants: ALU op codes, mul/div op encodings and the
// mul/div FSM state encoding.
package mips_pkg;

    // ALU operation select
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_SLL = 4'd7;

    // Mul/div op: bit 1 selects divide, bit 0 selects signed
    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_MULT  = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    // Mul/div FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIX  = 2'd3;

endpackage

// File: rtl/mips_muldiv_dp.sv
// Mul/div datapath: operand capture, shift-add / restoring-divide step,
// sign fix and the architectural HI/LO registers.
// Optional MIPS_MULDIV_EARLY_OUT_EN: exposes the "remaining multiplier bits
// are zero" flag and realigns a short-cut product by the remaining count.
module mips_muldiv_dp
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step_mul,
    input  logic             step_div,
    input  logic             commit,
    input  logic             wr_hi,
    input  logic             wr_lo,
`ifdef MIPS_MULDIV_EARLY_OUT_EN
    input  logic [CNTW-1:0]  cnt,
    output logic             mul_rest_zero,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0]   md;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   mq;       // multiplier, or dividend shifting into quotient
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   a_raw;
    logic               sign_q;
    logic               sign_r;
    logic               div_zero;
    logic               is_div;

    logic               is_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod_adj;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign is_signed = op[0];
    assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;

    // One shift-add step and one restoring-divide step, computed every cycle
    always_comb begin
        sum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + (mq[0] ? {1'b0, md} : '0);
        shifted = {rem, mq[WIDTH-1]};
        diff    = shifted - {1'b0, md};
    end

    // Result realignment and sign fix applied in FIX
    always_comb begin
`ifdef MIPS_MULDIV_EARLY_OUT_EN
        prod_adj = prod >> cnt;
`else
        prod_adj = prod;
`endif
        prod_fix = sign_q ? -prod_adj : prod_adj;
        quo_fix  = sign_q ? -mq : mq;
        rem_fix  = sign_r ? -rem : rem;
    end

`ifdef MIPS_MULDIV_EARLY_OUT_EN
    assign mul_rest_zero = (mq[WIDTH-1:1] == '0);
`endif

    // Operand capture and iteration registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md       <= '0;
            mq       <= '0;
            rem      <= '0;
            prod     <= '0;
            a_raw    <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            div_zero <= 1'b0;
            is_div   <= 1'b0;
        end else if (load) begin
            md       <= op[1] ? b_mag : a_mag;
            mq       <= op[1] ? a_mag : b_mag;
            rem      <= '0;
            prod     <= '0;
            a_raw    <= a;
            sign_q   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_r   <= is_signed & a[WIDTH-1];
            div_zero <= op[1] & (b == '0);
            is_div   <= op[1];
        end else if (step_mul) begin
            prod <= {sum, prod[WIDTH-1:1]};
            mq   <= mq >> 1;
        end else if (step_div) begin
            // diff[WIDTH] set means the trial subtract borrowed
            if (!diff[WIDTH]) begin
                rem <= diff[WIDTH-1:0];
                mq  <= {mq[WIDTH-2:0], 1'b1};
            end else begin
                rem <= shifted[WIDTH-1:0];
                mq  <= {mq[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Architectural HI/LO: result commit or MTHI/MTLO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            if (!is_div) begin
                hi <= prod_fix[2*WIDTH-1:WIDTH];
                lo <= prod_fix[WIDTH-1:0];
            end else if (div_zero) begin
                hi <= a_raw;
                lo <= '1;
            end else begin
                hi <= rem_fix;
                lo <= quo_fix;
            end
        end else begin
            if (wr_hi) hi <= a;
            if (wr_lo) lo <= a;
        end
    end

endmodule

// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit: FSM, iteration counter and
// busy/done handshake around mips_muldiv_dp.
// Optional MIPS_MULDIV_EARLY_OUT_EN: MUL leaves for FIX once the remaining
// multiplier bits are all zero (after at least one iteration).
//
// state | meaning
// IDLE  | waiting; accepts start, mthi, mtlo
// MUL   | one shift-add iteration per cycle
// DIV   | one restoring-divide iteration per cycle
// FIX   | sign fix and HI/LO write, then IDLE
module mips_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNTW-1:0] CNT_INIT = CNTW'(WIDTH);

    logic [1:0]      state;
    logic [1:0]      state_nx;
    logic [CNTW-1:0] cnt;
    logic            idle;
    logic            accept;
    logic            last_iter;
    logic            mul_exit;
`ifdef MIPS_MULDIV_EARLY_OUT_EN
    logic            mul_rest_zero;
`endif

    assign idle      = (state == ST_IDLE);
    assign accept    = idle && start && !flush;
    assign last_iter = (cnt == CNTW'(1));
    assign busy      = !idle;

`ifdef MIPS_MULDIV_EARLY_OUT_EN
    assign mul_exit = last_iter || mul_rest_zero;
`else
    assign mul_exit = last_iter;
`endif

    // Next-state logic; flush always wins
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = op[1] ? ST_DIV : ST_MUL;
            ST_MUL:  if (flush) state_nx = ST_IDLE;
                     else if (mul_exit) state_nx = ST_FIX;
            ST_DIV:  if (flush) state_nx = ST_IDLE;
                     else if (last_iter) state_nx = ST_FIX;
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Iteration down-counter; in FIX it holds the count left by an early exit
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (accept)
            cnt <= CNT_INIT;
        else if (flush || state == ST_FIX)
            cnt <= '0;
        else if (state == ST_MUL || state == ST_DIV)
            cnt <= cnt - 1'b1;
    end

    // Registered one-cycle done pulse following a committed FIX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done <= 1'b0;
        else     done <= (state == ST_FIX) && !flush;
    end

    mips_muldiv_dp #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) u_dp (
        .clk           (clk),
        .rst           (rst),
        .load          (accept),
        .op            (op),
        .a             (a),
        .b             (b),
        .step_mul      (state == ST_MUL && !flush),
        .step_div      (state == ST_DIV && !flush),
        .commit        (state == ST_FIX && !flush),
        .wr_hi         (idle && mthi && !start && !flush),
        .wr_lo         (idle && mtlo && !start && !flush),
`ifdef MIPS_MULDIV_EARLY_OUT_EN
        .cnt           (cnt),
        .mul_rest_zero (mul_rest_zero),
`endif
        .hi            (hi),
        .lo            (lo)
    );

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed-vector bench for mips_muldiv (WIDTH=32).
module tb_mips_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk  = 0;
    int n_pass = 0;

    mips_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Expected done cycle counted from the start edge
    function automatic int exp_done(input logic [1:0] o, input logic [31:0] bv);
        int          n;
        int          k;
        logic [31:0] m;
        n = 34;
        m = (o[0] && bv[31]) ? -bv : bv;
        k = 1;
        for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
`ifdef MIPS_MULDIV_EARLY_OUT_EN
        if (!o[1]) n = k + 2;
`endif
        return n;
    endfunction

    // Issue one op, watch 45 cycles: done cycle, pulse count, first busy-low cycle, result
    task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                          output int done_cyc, output int n_done, output int busy_low,
                          output logic [31:0] r_hi, output logic [31:0] r_lo);
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk);
        #1 start = 1'b0;
        done_cyc = -1; n_done = 0; busy_low = -1; r_hi = 'x; r_lo = 'x;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = c; r_hi = hi; r_lo = lo;
                end
            end
            if (!busy && busy_low < 0) busy_low = c;
        end
    endtask

    initial begin
        int          dc, nd, bl;
        logic [31:0] rh, rl;
        int          flush_cyc;

        vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2]  = '{2'b10, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
        vecs[3]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{2'b10, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
        vecs[6]  = '{2'b11, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[7]  = '{2'b00, 32'h0000_0003, 32'h0000_0001, 32'h0000_0000, 32'h0000_0003};
        vecs[8]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[9]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[10] = '{2'b01, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[12] = '{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[13] = '{2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, dc, nd, bl, rh, rl);
            chk($sformatf("v%0d_hi", i), {32'd0, rh}, {32'd0, vecs[i].hi});
            chk($sformatf("v%0d_lo", i), {32'd0, rl}, {32'd0, vecs[i].lo});
            chk($sformatf("v%0d_done_cycle", i), 64'(dc), 64'(exp_done(vecs[i].op, vecs[i].b)));
            chk($sformatf("v%0d_done_pulses", i), 64'(nd), 64'd1);
            chk($sformatf("v%0d_busy_fall", i), 64'(bl), 64'(exp_done(vecs[i].op, vecs[i].b)));
        end

        // mthi + mtlo together, then separately
        @(negedge clk); mthi = 1'b1; mtlo = 1'b1; a = 32'hAB;
        @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
        chk("mthi_mtlo_both", {hi, lo}, {32'hAB, 32'hAB});
        a = 32'h11; mthi = 1'b1;
        @(negedge clk); mthi = 1'b0; a = 32'h22; mtlo = 1'b1;
        @(negedge clk); mtlo = 1'b0;
        chk("preload_hilo", {hi, lo}, {32'h11, 32'h22});

        // Flush mid-MUL: busy drops next cycle, HI/LO untouched, no done
`ifdef MIPS_MULDIV_EARLY_OUT_EN
        flush_cyc = 3;
`else
        flush_cyc = 10;
`endif
        start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
        @(posedge clk);
        #1 start = 1'b0;
        nd = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (done) nd++;
            if (c == flush_cyc) chk("flush_busy_before", {63'd0, busy}, 64'd1);
            if (c == flush_cyc + 1) chk("flush_busy_after", {63'd0, busy}, 64'd0);
            flush = (c == flush_cyc);
        end
        flush = 1'b0;
        chk("flush_no_done", 64'(nd), 64'd0);
        chk("flush_hilo_kept", {hi, lo}, {32'h11, 32'h22});

        // Flush in IDLE drops a simultaneous start
        @(negedge clk); start = 1'b1; flush = 1'b1; op = 2'b10; a = 32'd50; b = 32'd3;
        @(negedge clk); start = 1'b0; flush = 1'b0;
        chk("idle_flush_drops_start", {63'd0, busy}, 64'd0);

        // Start during DIVU is ignored and does not queue
        @(negedge clk); start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        nd = 0; dc = -1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (done) begin nd++; if (dc < 0) dc = c; end
            start = (c == 5);
            if (c == 5) begin op = 2'b00; a = 32'd1; b = 32'd1; end
        end
        start = 1'b0;
        chk("busy_start_single_done", 64'(nd), 64'd1);
        chk("busy_start_done_cycle", 64'(dc), 64'd34);
        chk("busy_start_result", {hi, lo}, {32'd2, 32'd14});
        chk("busy_start_not_queued", {63'd0, busy}, 64'd0);

        // Asynchronous reset mid-MUL, then a normal op
        @(negedge clk); start = 1'b1; op = 2'b00; a = 32'hFFFF; b = 32'hFFFF;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", {63'd0, busy}, 64'd0);
        chk("async_rst_done", {63'd0, done}, 64'd0);
        chk("async_rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk); rst = 1'b0;
        run_op(2'b00, 32'd6, 32'd7, dc, nd, bl, rh, rl);
        chk("post_rst_result", {rh, rl}, {32'd0, 32'd42});
        chk("post_rst_done_cycle", 64'(dc), 64'(exp_done(2'b00, 32'd7)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
